// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: sequences 16-bit weight beats into the per-layer weight buffer.
// Optional idle watchdog is built in when WEIGHT_LOAD_TIMEOUT_EN is defined.
module weight_load_ctrl #(
    parameter int DATA_W   = 16,
    parameter int L1_WORDS = 216,
    parameter int L8_WORDS = 576,
    parameter int L7_WORDS = 400
`ifdef WEIGHT_LOAD_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 1023
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        layer_sel,
    input  logic              abort,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    output logic              write_weight_signal,
    output logic [DATA_W-1:0] write_weight_data,
    output logic [15:0]       write_weight_addr,
    output logic [3:0]        weight_fsm_cs,
    output logic              weight_store_done,
    output logic              rd_allow,
    output logic              cmd_err,
    output logic              timeout_err
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0000,
        S_L1     = 4'b0001,
        S_L2     = 4'b0010,
        S_L4     = 4'b0011,
        S_L5     = 4'b0100,
        S_L7     = 4'b0101,
        S_FINISH = 4'b1111
    } state_t;

    state_t     state, state_nxt;
    logic [9:0] word_cnt, word_cnt_nxt;
    logic [2:0] grp_cnt, grp_cnt_nxt;
    logic       abort_pend, abort_pend_nxt;
    logic       cmd_err_nxt;
    logic       in_load, abort_eff, beat;

    function automatic logic [9:0] last_word(input state_t s);
        case (s)
            S_L1:    last_word = 10'(L1_WORDS - 1);
            S_L7:    last_word = 10'(L7_WORDS - 1);
            default: last_word = 10'(L8_WORDS - 1);
        endcase
    endfunction

    function automatic logic [2:0] grp_last(input state_t s);
        grp_last = (s == S_L1) ? 3'd2 : 3'd7;
    endfunction

    assign in_load   = (state == S_L1) || (state == S_L2) || (state == S_L4) ||
                       (state == S_L5) || (state == S_L7);
    assign abort_eff = in_load && (abort || abort_pend);
    // A pending abort at a group boundary refuses further beats so no partial group is started.
    assign w_ready   = in_load && !(abort_eff && (grp_cnt == 3'd0));
    assign beat      = w_valid && w_ready;

    assign write_weight_signal = beat;
    assign write_weight_data   = beat ? w_data : '0;
    assign write_weight_addr   = 16'(word_cnt);
    assign weight_fsm_cs       = state;
    assign weight_store_done   = (state == S_FINISH);
    assign rd_allow            = (state == S_IDLE);

`ifdef WEIGHT_LOAD_TIMEOUT_EN
    logic [9:0] idle_cnt, idle_cnt_nxt;
    logic       timeout_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            idle_cnt    <= idle_cnt_nxt;
            timeout_err <= timeout_nxt;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            grp_cnt    <= '0;
            abort_pend <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_cnt   <= word_cnt_nxt;
            grp_cnt    <= grp_cnt_nxt;
            abort_pend <= abort_pend_nxt;
            cmd_err    <= cmd_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        word_cnt_nxt   = word_cnt;
        grp_cnt_nxt    = grp_cnt;
        abort_pend_nxt = 1'b0;
        cmd_err_nxt    = 1'b0;
`ifdef WEIGHT_LOAD_TIMEOUT_EN
        idle_cnt_nxt   = '0;
        timeout_nxt    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (layer_sel)
                        3'd1:    state_nxt = S_L1;
                        3'd2:    state_nxt = S_L2;
                        3'd4:    state_nxt = S_L4;
                        3'd5:    state_nxt = S_L5;
                        3'd7:    state_nxt = S_L7;
                        default: cmd_err_nxt = 1'b1;
                    endcase
                end
            end
            S_L1, S_L2, S_L4, S_L5, S_L7: begin
                abort_pend_nxt = abort_eff;
                if (beat) begin
                    // Completion outranks a simultaneous abort.
                    if (word_cnt == last_word(state)) begin
                        state_nxt      = S_FINISH;
                        word_cnt_nxt   = '0;
                        grp_cnt_nxt    = '0;
                        abort_pend_nxt = 1'b0;
                    end else if (abort_eff && (grp_cnt == grp_last(state))) begin
                        state_nxt      = S_IDLE;
                        word_cnt_nxt   = '0;
                        grp_cnt_nxt    = '0;
                        abort_pend_nxt = 1'b0;
                    end else begin
                        word_cnt_nxt = word_cnt + 10'd1;
                        grp_cnt_nxt  = (grp_cnt == grp_last(state)) ? 3'd0 : grp_cnt + 3'd1;
                    end
                end else if (abort_eff && (grp_cnt == 3'd0)) begin
                    state_nxt      = S_IDLE;
                    word_cnt_nxt   = '0;
                    grp_cnt_nxt    = '0;
                    abort_pend_nxt = 1'b0;
                end
`ifdef WEIGHT_LOAD_TIMEOUT_EN
                else if (idle_cnt == 10'(TIMEOUT - 1)) begin
                    state_nxt      = S_IDLE;
                    word_cnt_nxt   = '0;
                    grp_cnt_nxt    = '0;
                    abort_pend_nxt = 1'b0;
                    timeout_nxt    = 1'b1;
                end else begin
                    idle_cnt_nxt = idle_cnt + 10'd1;
                end
`endif
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: per-cycle model compare plus directed literal checks.
module tb_weight_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  layer_sel = 3'd0;
    logic        abort = 1'b0;
    logic        w_valid = 1'b0;
    logic [15:0] w_data = 16'd0;
    logic        w_ready, write_weight_signal, weight_store_done, rd_allow, cmd_err, timeout_err;
    logic [15:0] write_weight_data, write_weight_addr;
    logic [3:0]  weight_fsm_cs;

`ifdef WEIGHT_LOAD_TIMEOUT_EN
    localparam int TIMEOUT = 1023;
`endif

    weight_load_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .abort(abort),
        .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .write_weight_signal(write_weight_signal), .write_weight_data(write_weight_data),
        .write_weight_addr(write_weight_addr), .weight_fsm_cs(weight_fsm_cs),
        .weight_store_done(weight_store_done), .rd_allow(rd_allow),
        .cmd_err(cmd_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int k);
        return 16'(k * 37 + 256);
    endfunction

    // ---------------- behavioural model ----------------
    int m_layer = 0;   // 0 = idle, otherwise the layer being loaded
    bit m_fin   = 0;
    int m_n     = 0;   // beats accepted in the current load
    bit m_abort = 0;
    bit m_err   = 0;
    bit m_to    = 0;
    int m_idle  = 0;
    bit m_acc, m_ab;

    function automatic int words(input int l);
        if (l == 1) return 216;
        if (l == 7) return 400;
        return 576;
    endfunction

    function automatic int grp(input int l);
        return (l == 1) ? 3 : 8;
    endfunction

    function automatic logic [3:0] exp_cs();
        if (m_fin) return 4'hF;
        case (m_layer)
            1: return 4'd1;
            2: return 4'd2;
            4: return 4'd3;
            5: return 4'd4;
            7: return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    function automatic bit exp_ready();
        if (m_fin || m_layer == 0) return 1'b0;
        return !((abort || m_abort) && (m_n % grp(m_layer) == 0));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_layer = 0; m_fin = 0; m_n = 0; m_abort = 0; m_err = 0; m_to = 0; m_idle = 0;
        end else begin
            m_acc = w_valid && exp_ready();
            m_ab  = abort || m_abort;
            m_err = 0;
            m_to  = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (m_layer == 0) begin
                if (start) begin
                    if (layer_sel inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd7}) begin
                        m_layer = int'(layer_sel); m_n = 0; m_idle = 0; m_abort = 0;
                    end else m_err = 1;
                end
            end else if (m_acc) begin
                m_n++;
                m_idle = 0;
                if (m_n == words(m_layer)) begin
                    m_fin = 1; m_layer = 0; m_n = 0; m_abort = 0;
                end else if (m_ab && (m_n % grp(m_layer) == 0)) begin
                    m_layer = 0; m_n = 0; m_abort = 0;
                end else m_abort = m_ab;
            end else if (m_ab && (m_n % grp(m_layer) == 0)) begin
                m_layer = 0; m_n = 0; m_abort = 0;
            end else begin
                m_abort = m_ab;
                m_idle++;
`ifdef WEIGHT_LOAD_TIMEOUT_EN
                if (m_idle >= TIMEOUT) begin
                    m_layer = 0; m_n = 0; m_abort = 0; m_idle = 0; m_to = 1;
                end
`endif
            end
        end
    end

    // ---------------- compare + statistics ----------------
    int n_wr = 0, n_done = 0, n_err = 0, n_to = 0, first_addr = -1, last_addr = -1;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cs",          32'(weight_fsm_cs), 32'(exp_cs()));
            chk("w_ready",     32'(w_ready), 32'(exp_ready()));
            chk("rd_allow",    32'(rd_allow), 32'(!m_fin && m_layer == 0));
            chk("done",        32'(weight_store_done), 32'(m_fin));
            chk("strobe",      32'(write_weight_signal), 32'(w_valid && exp_ready()));
            chk("addr",        32'(write_weight_addr), 32'(m_n));
            chk("cmd_err",     32'(cmd_err), 32'(m_err));
            chk("timeout_err", 32'(timeout_err), 32'(m_to));
            if (write_weight_signal) begin
                chk("data",     32'(write_weight_data), 32'(w_data));
                chk("data_seq", 32'(write_weight_data), 32'(pat(int'(write_weight_addr))));
                if (n_wr == 0) first_addr = int'(write_weight_addr);
                last_addr = int'(write_weight_addr);
                n_wr++;
            end
            if (weight_store_done) n_done++;
            if (cmd_err) n_err++;
            if (timeout_err) n_to++;
        end
    end

    task automatic clear_stats();
        n_wr = 0; n_done = 0; n_err = 0; n_to = 0; first_addr = -1; last_addr = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [2:0] sel);
        start = 1'b1;
        layer_sel = sel;
        tick();
        start = 1'b0;
    endtask

    // Offers beats until n are accepted; abort/stray start pulse once when k reaches the given index.
    task automatic drive(input int n, input int gap_pct, input int abort_at, input int start_at,
                         output int acc_n);
        int k = 0;
        int cyc = 0;
        bit acc;
        bit ab_fired = 0;
        bit st_fired = 0;
        while (k < n && cyc < 4000) begin
            w_valid = ($urandom_range(0, 99) >= gap_pct);
            w_data  = pat(k);
            if (k == abort_at && !ab_fired) begin abort = 1'b1; ab_fired = 1; end
            if (k == start_at && !st_fired) begin start = 1'b1; layer_sel = 3'd1; st_fired = 1; end
            @(negedge clk);
            acc = w_valid && w_ready;
            tick();
            abort = 1'b0;
            start = 1'b0;
            if (acc) k++;
            cyc++;
        end
        w_valid = 1'b0;
        acc_n = k;
        chk("drive_bound", 32'(cyc < 4000), 32'd1);
    endtask

    int acc_n, waited;

    initial begin
        #1 rst = 1'b1;
        #3;
        chk("rst_cs",      32'(weight_fsm_cs), 32'd0);
        chk("rst_rd",      32'(rd_allow), 32'd1);
        chk("rst_ready",   32'(w_ready), 32'd0);
        chk("rst_done",    32'(weight_store_done), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_to",      32'(timeout_err), 32'd0);
        tick();
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // T1: layer 1 back-to-back
        clear_stats();
        start_load(3'd1);
        chk("t1_cs", 32'(weight_fsm_cs), 32'd1);
        drive(216, 0, -1, -1, acc_n);
        chk("t1_fin_cs", 32'(weight_fsm_cs), 32'hF);
        chk("t1_done_now", 32'(weight_store_done), 32'd1);
        tick();
        chk("t1_rd", 32'(rd_allow), 32'd1);
        chk("t1_writes", 32'(n_wr), 32'd216);
        chk("t1_first", 32'(first_addr), 32'd0);
        chk("t1_last", 32'(last_addr), 32'd215);
        chk("t1_dones", 32'(n_done), 32'd1);

        // T2: layer 7 with ~30% idle gaps
        clear_stats();
        start_load(3'd7);
        drive(400, 30, -1, -1, acc_n);
        tick(); tick();
        chk("t2_writes", 32'(n_wr), 32'd400);
        chk("t2_last", 32'(last_addr), 32'd399);
        chk("t2_dones", 32'(n_done), 32'd1);

        // T3: illegal starts, then a stray start during an L2 load
        clear_stats();
        for (int i = 0; i < 3; i++) begin
            start_load((i == 0) ? 3'd0 : (i == 1) ? 3'd3 : 3'd6);
            chk("t3_cs", 32'(weight_fsm_cs), 32'd0);
            chk("t3_ready", 32'(w_ready), 32'd0);
            tick();
        end
        chk("t3_errs", 32'(n_err), 32'd3);
        clear_stats();
        start_load(3'd2);
        drive(576, 0, -1, 5, acc_n);
        tick();
        chk("t3_writes", 32'(n_wr), 32'd576);
        chk("t3_dones", 32'(n_done), 32'd1);
        chk("t3_noerr", 32'(n_err), 32'd0);

        // Abort right at a group boundary: no beat accepted, back to idle
        clear_stats();
        start_load(3'd1);
        abort = 1'b1;
        w_valid = 1'b1;
        w_data = pat(0);
        @(negedge clk);
        chk("ab0_ready", 32'(w_ready), 32'd0);
        chk("ab0_strobe", 32'(write_weight_signal), 32'd0);
        tick();
        abort = 1'b0;
        w_valid = 1'b0;
        chk("ab0_cs", 32'(weight_fsm_cs), 32'd0);
        chk("ab0_writes", 32'(n_wr), 32'd0);

        // T4: abort at word 11 of L4 finishes the group at word 15
        clear_stats();
        start_load(3'd4);
        drive(16, 0, 11, -1, acc_n);
        chk("t4_acc", 32'(acc_n), 32'd16);
        chk("t4_cs", 32'(weight_fsm_cs), 32'd0);
        chk("t4_ready", 32'(w_ready), 32'd0);
        tick();
        chk("t4_last", 32'(last_addr), 32'd15);
        chk("t4_dones", 32'(n_done), 32'd0);
        clear_stats();
        start_load(3'd4);
        drive(576, 0, -1, -1, acc_n);
        tick();
        chk("t4_first", 32'(first_addr), 32'd0);
        chk("t4_writes", 32'(n_wr), 32'd576);
        chk("t4_dones2", 32'(n_done), 32'd1);

        // T5: async reset mid-load of L5
        clear_stats();
        start_load(3'd5);
        drive(100, 0, -1, -1, acc_n);
        w_valid = 1'b1;
        w_data = pat(100);
        #2 rst = 1'b1;
        #1;
        chk("t5_cs", 32'(weight_fsm_cs), 32'd0);
        chk("t5_ready", 32'(w_ready), 32'd0);
        chk("t5_strobe", 32'(write_weight_signal), 32'd0);
        chk("t5_addr", 32'(write_weight_addr), 32'd0);
        chk("t5_rd", 32'(rd_allow), 32'd1);
        w_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        clear_stats();
        start_load(3'd5);
        drive(576, 0, -1, -1, acc_n);
        tick();
        chk("t5_first", 32'(first_addr), 32'd0);
        chk("t5_writes", 32'(n_wr), 32'd576);
        chk("t5_dones", 32'(n_done), 32'd1);

`ifdef WEIGHT_LOAD_TIMEOUT_EN
        // T6: watchdog after 10 beats of L2
        clear_stats();
        start_load(3'd2);
        drive(10, 0, -1, -1, acc_n);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!timeout_err && waited < 1100);
        chk("t6_wait", 32'(waited), 32'd1024);
        chk("t6_cs", 32'(weight_fsm_cs), 32'd0);
        chk("t6_rd", 32'(rd_allow), 32'd1);
        chk("t6_dones", 32'(n_done), 32'd0);
        tick();
`else
        waited = 0;
        clear_stats();
        start_load(3'd2);
        repeat (50) tick();
        chk("t6_wait_cs", 32'(weight_fsm_cs), 32'd2);
        chk("t6_no_to", 32'(n_to), 32'(waited));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_cs", 32'(weight_fsm_cs), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
